// File: rtl/raycast_pkg.sv
// Shared types and screen geometry for the ray-cast column pipeline.
package raycast_pkg;

  localparam int unsigned SCREEN_WIDTH  = 320;
  localparam int unsigned SCREEN_HEIGHT = 180;
  localparam int unsigned PIXEL_WIDTH   = 16;
  localparam int unsigned COL_W         = 9;
  localparam int unsigned HEIGHT_W      = 8;
  localparam int unsigned ROW_W         = 8;
  localparam int unsigned ADDR_W        = 16;

  localparam logic [PIXEL_WIDTH-1:0] CEILING_COLOR = 16'h0000;
  localparam logic [PIXEL_WIDTH-1:0] FLOOR_COLOR   = 16'h4208;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic {IDLE, DRAW} flat_state_t;

  typedef struct packed {
    logic [COL_W-1:0]    col;
    logic [HEIGHT_W-1:0] height;
    rgb565_t             color;
    logic                side;
    logic                last;
  } ray_result_t;

  // Wall heights taller than the screen fill the whole column.
  function automatic logic [HEIGHT_W-1:0] clamp_height(input logic [HEIGHT_W-1:0] h);
    return (h > HEIGHT_W'(SCREEN_HEIGHT)) ? HEIGHT_W'(SCREEN_HEIGHT) : h;
  endfunction

endpackage

// File: rtl/rgb565_shade.sv
// Field-wise halving of an RGB565 colour for side-shaded walls.
// Only present when SHADE_SIDE_EN is defined.
`ifdef SHADE_SIDE_EN
module rgb565_shade
  import raycast_pkg::*;
(
  input  rgb565_t color,
  output rgb565_t shaded_c
);

  always_comb begin
    shaded_c.r = color.r >> 1;
    shaded_c.g = color.g >> 1;
    shaded_c.b = color.b >> 1;
  end

endmodule
`endif

// File: rtl/column_flattener.sv
// Expands one ray result per column into SCREEN_HEIGHT addressed RGB565 pixels.
// Optional SHADE_SIDE_EN darkens walls hit on side 1.
module column_flattener
  import raycast_pkg::*;
(
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic                   ray_valid_in,
  output logic                   ray_ready_out,
  input  logic [COL_W-1:0]       col_in,
  input  logic [HEIGHT_W-1:0]    line_height_in,
  input  logic [PIXEL_WIDTH-1:0] wall_color_in,
  input  logic                   side_in,
  input  logic                   col_last_in,
  output logic [ADDR_W-1:0]      address_out,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   pixel_valid_out,
  output logic                   ray_last_pixel_out
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCREEN_HEIGHT - 1);

  flat_state_t           state, state_next;
  ray_result_t           ray, ray_next;
  logic [ROW_W-1:0]      row, row_next;
  logic [ADDR_W-1:0]     addr_next;
  logic                  accept;
  logic                  valid_next, last_next, ready_next;
  logic [ROW_W-1:0]      wall_start, wall_stop;
  rgb565_t               wall_color;
  logic [PIXEL_WIDTH-1:0] pixel_next;

  // Outputs are registered from the next row, so row 0 lands the cycle after acceptance.
  always_comb begin
    state_next = state;
    ray_next   = ray;
    row_next   = row;
    addr_next  = address_out;
    accept     = ray_valid_in & ray_ready_out;

    if (accept) begin
      state_next      = DRAW;
      ray_next.col    = col_in;
      ray_next.height = clamp_height(line_height_in);
      ray_next.color  = rgb565_t'(wall_color_in);
      ray_next.side   = side_in;
      ray_next.last   = col_last_in;
      row_next        = '0;
      addr_next       = ADDR_W'(col_in);
    end else if (state == DRAW && row != LAST_ROW) begin
      row_next  = row + ROW_W'(1);
      addr_next = address_out + ADDR_W'(SCREEN_WIDTH);
    end else begin
      state_next = IDLE;
    end

    valid_next = (state_next == DRAW) && (ray_next.col < COL_W'(SCREEN_WIDTH));
    last_next  = (state_next == DRAW) && (row_next == LAST_ROW) && ray_next.last;
    ready_next = (state_next == IDLE) || (row_next == LAST_ROW);
  end

`ifdef SHADE_SIDE_EN
  rgb565_t shaded;

  rgb565_shade u_shade (
    .color    (ray_next.color),
    .shaded_c (shaded)
  );

  assign wall_color = ray_next.side ? shaded : ray_next.color;
`else
  assign wall_color = ray_next.color;
`endif

  // Wall band is centred; an odd leftover row goes to the floor.
  always_comb begin
    wall_start = (ROW_W'(SCREEN_HEIGHT) - ray_next.height) >> 1;
    wall_stop  = wall_start + ray_next.height;
    pixel_next = FLOOR_COLOR;
    if (row_next < wall_start) begin
      pixel_next = CEILING_COLOR;
    end else if (row_next < wall_stop) begin
      pixel_next = wall_color;
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      ray                <= '0;
      row                <= '0;
      address_out        <= '0;
      pixel_out          <= '0;
      pixel_valid_out    <= 1'b0;
      ray_last_pixel_out <= 1'b0;
      ray_ready_out      <= 1'b1;
    end else begin
      ray                <= ray_next;
      row                <= row_next;
      address_out        <= addr_next;
      pixel_out          <= pixel_next;
      pixel_valid_out    <= valid_next;
      ray_last_pixel_out <= last_next;
      ray_ready_out      <= ready_next;
    end
  end

endmodule

// File: tb/tb_column_flattener.sv
// Scoreboard bench for column_flattener: driver predicts pixels, monitor checks them.
module tb_column_flattener;

`ifdef SHADE_SIDE_EN
  localparam bit SHADE = 1'b1;
`else
  localparam bit SHADE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ray_valid;
  logic        ready;
  logic [8:0]  col;
  logic [7:0]  height;
  logic [15:0] color;
  logic        side;
  logic        last;
  logic [15:0] address;
  logic [15:0] pixel;
  logic        pixel_valid;
  logic        last_pixel;

  always #5 clk = ~clk;

  column_flattener dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst),
    .ray_valid_in       (ray_valid),
    .ray_ready_out      (ready),
    .col_in             (col),
    .line_height_in     (height),
    .wall_color_in      (color),
    .side_in            (side),
    .col_last_in        (last),
    .address_out        (address),
    .pixel_out          (pixel),
    .pixel_valid_out    (pixel_valid),
    .ray_last_pixel_out (last_pixel)
  );

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
    logic [15:0] pix;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned busy_end = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned exp_lasts = 0;
  int unsigned obs_lasts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference colour of a row, straight from the ceiling/wall/floor rules.
  function automatic logic [15:0] model_pixel(input int r, input int h, input logic [15:0] c,
                                              input logic sd);
    int hc;
    int top;
    hc  = (h > 180) ? 180 : h;
    top = (180 - hc) / 2;
    if (r < top) return 16'h0000;
    if (r >= top + hc) return 16'h4208;
    if (SHADE && sd) return {1'b0, c[15:12], 1'b0, c[10:6], 1'b0, c[4:1]};
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_ray(input int c, input int h, input logic [15:0] clr, input logic sd,
                          input logic lst);
    int waited = 0;
    ray_valid = 1'b1;
    col       = 9'(c);
    height    = 8'(h);
    color     = clr;
    side      = sd;
    last      = lst;
    forever begin
      check("ready_wait", 32'(ready), 32'(cyc >= busy_end));
      if (ready) break;
      waited++;
      if (waited > 400) begin
        check("accept_timeout", 32'(waited), 32'd400);
        ray_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    for (int r = 0; r < 180; r++) begin
      if (c < 320)
        sb.push_back('{cyc + 1 + r, 16'(c + 320 * r), model_pixel(r, h, clr, sd),
                       lst && (r == 179)});
    end
    if (lst) exp_lasts++;
    busy_end = cyc + 180;
    @(negedge clk);
    ray_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      check("ready_idle", 32'(ready), 32'(cyc >= busy_end));
      @(negedge clk);
    end
  endtask

  // Monitor: every presented pixel must be the next expected one, on its expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (last_pixel) obs_lasts++;
      if (pixel_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_pixel", 32'(address), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("pixel_cycle", e.cyc == cyc ? e.cyc : cyc, e.cyc);
          check("address", 32'(address), 32'(e.addr));
          check("pixel", 32'(pixel), 32'(e.pix));
          check("last_flag", 32'(last_pixel), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 10000", cyc);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    ray_valid = 1'b0;
    col       = '0;
    height    = '0;
    color     = '0;
    side      = 1'b0;
    last      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_valid", 32'(pixel_valid), 32'd0);
    check("reset_last", 32'(last_pixel), 32'd0);
    check("reset_addr", 32'(address), 32'd0);
    check("reset_pixel", 32'(pixel), 32'd0);
    check("reset_ready", 32'(ready), 32'd1);
    idle(2);

    send_ray(5, 60, 16'hF800, 1'b0, 1'b0);
    idle(182);
    send_ray(319, 180, 16'h001F, 1'b0, 1'b1);
    idle(185);

    // Back-to-back columns covering clamp, empty and odd-split heights.
    send_ray(11, 200, 16'h07E0, 1'b0, 1'b0);
    send_ray(12, 0, 16'h1234, 1'b0, 1'b0);
    send_ray(13, 61, 16'hABCD, 1'b0, 1'b0);
    send_ray(14, 100, 16'hFFFF, 1'b1, 1'b0);
    idle(185);

    // Out-of-range column: no valid pixels, but its last flag still pulses.
    send_ray(330, 50, 16'h5555, 1'b0, 1'b1);
    idle(3);

    for (int i = 0; i < 20; i++) begin
      int c;
      int gap;
      c   = (i % 7 == 6) ? $urandom_range(320, 511) : $urandom_range(0, 319);
      gap = $urandom_range(0, 3);
      send_ray(c, $urandom_range(0, 255), 16'($urandom), 1'($urandom), 1'($urandom));
      if (gap != 0) idle(gap);
    end
    idle(200);

    // Asynchronous reset in the middle of a column.
    send_ray(50, 90, 16'h07E0, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    exp_lasts = exp_lasts - 1;
    #1;
    check("async_rst_valid", 32'(pixel_valid), 32'd0);
    check("async_rst_last", 32'(last_pixel), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    busy_end = cyc;
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_valid", 32'(pixel_valid), 32'd0);
    idle(2);
    send_ray(7, 40, 16'hF00F, 1'b0, 1'b0);
    idle(200);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("last_pulse_count", 32'(obs_lasts), 32'(exp_lasts));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
